// File: rtl/fmul_72bit_pkg.sv
// Shared widths, constants and stage-register layouts for the 72-bit
// floating-point multiplier back end.
package fmul_72bit_pkg;

  localparam int EXP_W   = 11;
  localparam int FRACT_W = 60;
  localparam int PROD_W  = 122;
  localparam int MANT_W  = FRACT_W + 1;
  localparam int EXPI_W  = 13;
  localparam int E0_W    = 14;
  localparam int EXP_MAX = 2047;

  localparam logic [71:0] NAN_CANON = 72'h7FF_800000000000000;

  typedef struct packed {
    logic nan_inv;  // NaN operand, or inf times zero
    logic inf;
    logic zero;
  } op_class_t;

  typedef struct packed {
    logic                   sign;
    logic signed [E0_W-1:0] e0;
    logic [MANT_W-1:0]      mant;
    logic                   g;
    logic                   s;
    op_class_t              cls;
  } stage0_t;

  typedef struct packed {
    logic [71:0] data;
    logic [3:0]  flags;
  } result_t;

  // Exception bits arrive as {zA, zB, maxA, maxB, fzA, fzB}.
  function automatic op_class_t classify(input logic [5:0] x);
    op_class_t c;
    logic inf_a, inf_b, nan_a, nan_b;
    inf_a     = x[3] & x[1];
    inf_b     = x[2] & x[0];
    nan_a     = x[3] & ~x[1];
    nan_b     = x[2] & ~x[0];
    c.nan_inv = nan_a | nan_b | (inf_a & x[4]) | (inf_b & x[5]);
    c.inf     = inf_a | inf_b;
    c.zero    = x[5] | x[4];
    return c;
  endfunction

endpackage

// File: rtl/fmul_72bit_pipe_reg.sv
// One pipeline stage: valid plus payload, frozen while downstream is busy,
// cleared by either reset.
module fmul_72bit_pipe_reg #(
  parameter int W = 1
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iRESET_SYNC,
  input  logic         iBUSY,
  input  logic         iVALID,
  input  logic [W-1:0] iDATA,
  output logic         oVALID,
  output logic [W-1:0] oDATA
);

  // NOTE: payload is reset along with valid so the outputs read all-zero
  // after reset; non-blocking assignments keep every stage sampling the
  // pre-edge value of its predecessor.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else if (iRESET_SYNC) begin
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else if (!iBUSY) begin
      oVALID <= iVALID;
      oDATA  <= iDATA;
    end
  end

endmodule

// File: rtl/fmul_72bit_norm.sv
// Normalize, round-to-nearest-even and pack the raw significand product
// into a 72-bit result through a two-stage valid/busy pipeline.
module fmul_72bit_norm
  import fmul_72bit_pkg::*;
#(
  parameter int P_EXP_ADJ = 512
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iRESET_SYNC,
  input  logic              iDATA_REQ,
  output logic              oDATA_BUSY,
  input  logic              iDATA_SIGN,
  input  logic [EXPI_W-1:0] iDATA_EXP,
  input  logic [PROD_W-1:0] iDATA_FRACT,
  input  logic [5:0]        iDATA_EXCEPT,
  output logic              oDATA_VALID,
  input  logic              iDATA_BUSY,
  output logic [71:0]       oDATA_DATA,
  output logic [3:0]        oDATA_FLAGS
);

  localparam logic signed [E0_W-1:0] EXP_ADJ = E0_W'(P_EXP_ADJ);
  localparam logic signed [E0_W-1:0] E_OVF   = E0_W'(EXP_MAX);
  localparam logic signed [E0_W-1:0] E_ZERO  = '0;

  stage0_t s0_next, s0_q;
  result_t res_next, res_q;
  logic    s0_valid;

  logic                   norm_shift;
  logic signed [E0_W-1:0] exp_ext;
  logic                   inc;
  logic [MANT_W:0]        m1;
  logic signed [E0_W-1:0] e1;

  assign oDATA_BUSY = iDATA_BUSY;
  assign norm_shift = iDATA_FRACT[PROD_W-1];
  assign exp_ext    = {iDATA_EXP[EXPI_W-1], iDATA_EXP};

  // NOTE: every field gets a default first so no path leaves a latch.
  always_comb begin
    s0_next      = '0;
    s0_next.sign = iDATA_SIGN;
    if (norm_shift) begin
      s0_next.mant = iDATA_FRACT[PROD_W-1 -: MANT_W];
      s0_next.g    = iDATA_FRACT[FRACT_W];
      s0_next.s    = |iDATA_FRACT[FRACT_W-1:0];
    end else begin
      s0_next.mant = iDATA_FRACT[PROD_W-2 -: MANT_W];
      s0_next.g    = iDATA_FRACT[FRACT_W-1];
      s0_next.s    = |iDATA_FRACT[FRACT_W-2:0];
    end
    s0_next.e0  = exp_ext - EXP_ADJ + {{(E0_W-1){1'b0}}, norm_shift};
    s0_next.cls = classify(iDATA_EXCEPT);
  end

  fmul_72bit_pipe_reg #(.W($bits(stage0_t))) u_stage0 (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iBUSY       (iDATA_BUSY),
    .iVALID      (iDATA_REQ),
    .iDATA       (s0_next),
    .oVALID      (s0_valid),
    .oDATA       (s0_q)
  );

  // A carry out of the 61-bit significand leaves the low bits zero,
  // which is exactly the renormalized fraction.
  assign inc = s0_q.g & (s0_q.s | s0_q.mant[0]);
  assign m1  = {1'b0, s0_q.mant} + {{MANT_W{1'b0}}, inc};
  assign e1  = s0_q.e0 + {{(E0_W-1){1'b0}}, m1[MANT_W]};

  always_comb begin
    res_next = '0;
    if (s0_q.cls.nan_inv) begin
      res_next.data  = NAN_CANON;
      res_next.flags = 4'b1000;
    end else if (s0_q.cls.inf) begin
      res_next.data = {s0_q.sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
    end else if (s0_q.cls.zero) begin
      res_next.data = {s0_q.sign, 71'h0};
    end else if (e1 >= E_OVF) begin
      res_next.data  = {s0_q.sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
      res_next.flags = 4'b0101;
    end else if (e1 <= E_ZERO) begin
      res_next.data  = {s0_q.sign, 71'h0};
      res_next.flags = 4'b0011;
    end else begin
      res_next.data  = {s0_q.sign, e1[EXP_W-1:0], m1[FRACT_W-1:0]};
      res_next.flags = {3'b000, s0_q.g | s0_q.s};
    end
  end

  fmul_72bit_pipe_reg #(.W($bits(result_t))) u_stage1 (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iBUSY       (iDATA_BUSY),
    .iVALID      (s0_valid),
    .iDATA       (res_next),
    .oVALID      (oDATA_VALID),
    .oDATA       (res_q)
  );

  assign oDATA_DATA  = res_q.data;
  assign oDATA_FLAGS = res_q.flags;

endmodule

// File: tb/tb_fmul_72bit_norm.sv
// Scoreboard bench for fmul_72bit_norm: directed corner cases plus random
// significand products checked against an arithmetic reference model.
module tb_fmul_72bit_norm;

  logic         iCLOCK = 1'b0;
  logic         iRESET = 1'b1;
  logic         iRESET_SYNC = 1'b0;
  logic         iDATA_REQ = 1'b0;
  logic         oDATA_BUSY;
  logic         iDATA_SIGN = 1'b0;
  logic [12:0]  iDATA_EXP = '0;
  logic [121:0] iDATA_FRACT = '0;
  logic [5:0]   iDATA_EXCEPT = '0;
  logic         oDATA_VALID;
  logic         iDATA_BUSY = 1'b0;
  logic [71:0]  oDATA_DATA;
  logic [3:0]   oDATA_FLAGS;

  int errors = 0;
  int checks = 0;
  logic [75:0] sb[$];

  localparam logic [121:0] ONE = 122'd1;

  fmul_72bit_norm dut (
    .iCLOCK       (iCLOCK),
    .iRESET       (iRESET),
    .iRESET_SYNC  (iRESET_SYNC),
    .iDATA_REQ    (iDATA_REQ),
    .oDATA_BUSY   (oDATA_BUSY),
    .iDATA_SIGN   (iDATA_SIGN),
    .iDATA_EXP    (iDATA_EXP),
    .iDATA_FRACT  (iDATA_FRACT),
    .iDATA_EXCEPT (iDATA_EXCEPT),
    .oDATA_VALID  (oDATA_VALID),
    .iDATA_BUSY   (iDATA_BUSY),
    .oDATA_DATA   (oDATA_DATA),
    .oDATA_FLAGS  (oDATA_FLAGS)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: value-level rounding on the integer product.
  function automatic logic [75:0] model(input logic sg, input logic [12:0] ex,
                                        input logic [121:0] fr, input logic [5:0] xc);
    logic [121:0] unit, rem, half;
    logic [61:0]  mant;
    int           sh, e;
    logic         inf_a, inf_b, nan_a, nan_b, za, zb;
    za    = xc[5];
    zb    = xc[4];
    inf_a = xc[3] && xc[1];
    inf_b = xc[2] && xc[0];
    nan_a = xc[3] && !xc[1];
    nan_b = xc[2] && !xc[0];
    sh    = (fr >= (ONE << 121)) ? 61 : 60;
    unit  = ONE << sh;
    half  = unit >> 1;
    mant  = 62'(fr >> sh);
    rem   = fr % unit;
    e     = int'($signed(ex)) - 512 + (sh - 60);
    if (rem > half || (rem == half && mant[0])) mant = mant + 62'd1;
    if (mant == (62'd1 << 61)) begin
      mant = 62'd1 << 60;
      e    = e + 1;
    end
    if (nan_a || nan_b || (inf_a && zb) || (inf_b && za))
      return {72'h7FF_800000000000000, 4'b1000};
    if (inf_a || inf_b) return {sg, 11'h7FF, 60'h0, 4'b0000};
    if (za || zb)       return {sg, 71'h0, 4'b0000};
    if (e >= 2047)      return {sg, 11'h7FF, 60'h0, 4'b0101};
    if (e <= 0)         return {sg, 71'h0, 4'b0011};
    return {sg, 11'(e), mant[59:0], 3'b000, rem != 0};
  endfunction

  // Monitor: a result is consumed on an edge where busy is low.
  always @(negedge iCLOCK) begin
    if (!iRESET && oDATA_VALID) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, expected no output", {oDATA_DATA, oDATA_FLAGS});
      end else if (iDATA_BUSY) begin
        check("held_output", {oDATA_DATA, oDATA_FLAGS}, sb[0]);
      end else begin
        check("result", {oDATA_DATA, oDATA_FLAGS}, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic sg, input logic [12:0] ex, input logic [121:0] fr,
                       input logic [5:0] xc);
    iDATA_SIGN   = sg;
    iDATA_EXP    = ex;
    iDATA_FRACT  = fr;
    iDATA_EXCEPT = xc;
    iDATA_REQ    = 1'b1;
  endtask

  task automatic send(input logic sg, input logic [12:0] ex, input logic [121:0] fr,
                      input logic [5:0] xc, input logic [75:0] want);
    drive(sg, ex, fr, xc);
    sb.push_back(want);
    @(posedge iCLOCK);
    #1;
    iDATA_REQ = 1'b0;
  endtask

  task automatic send_model(input logic sg, input logic [12:0] ex, input logic [121:0] fr,
                            input logic [5:0] xc);
    send(sg, ex, fr, xc, model(sg, ex, fr, xc));
  endtask

  task automatic stall(input int n);
    iDATA_BUSY = 1'b1;
    repeat (n) begin
      @(posedge iCLOCK);
      #1;
    end
    iDATA_BUSY = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge iCLOCK);
      k++;
    end
    #1;
    check("drain_empty", 76'(sb.size()), 76'd0);
  endtask

  initial begin
    logic [60:0]  a, b;
    logic [12:0]  ex;
    logic [5:0]   xc;

    #1;
    check("reset_valid", 76'(oDATA_VALID), 76'd0);
    check("reset_data",  76'(oDATA_DATA),  76'd0);
    check("reset_flags", 76'(oDATA_FLAGS), 76'd0);
    repeat (2) @(posedge iCLOCK);
    #1;
    iRESET = 1'b0;

    // 1.0 x 1.0 with latency probe: valid after the second edge.
    send(1'b0, 13'd1535, ONE << 120, 6'b0, {72'h3FF_000000000000000, 4'b0000});
    @(negedge iCLOCK);
    check("latency_one_edge", 76'(oDATA_VALID), 76'd0);
    @(negedge iCLOCK);
    check("latency_two_edges", 76'(oDATA_VALID), 76'd1);

    send(1'b0, 13'd1535, (ONE << 121) + (ONE << 118), 6'b0, {72'h400_200000000000000, 4'b0000});
    send(1'b0, 13'd1535, (ONE << 120) + (ONE << 59), 6'b0, {72'h3FF_000000000000000, 4'b0001});
    send(1'b0, 13'd1535, (ONE << 120) + (ONE << 60) + (ONE << 59), 6'b0,
         {72'h3FF_000000000000002, 4'b0001});
    send(1'b1, 13'd3583, ONE << 120, 6'b0, {72'hFFF_000000000000000, 4'b0101});
    send(1'b1, 13'd0,    ONE << 120, 6'b0, {72'h800_000000000000000, 4'b0011});
    send(1'b1, 13'd1535, ONE << 120, 6'b010110, {72'h7FF_800000000000000, 4'b1000});
    send(1'b1, 13'd1535, ONE << 120, 6'b001010, {72'hFFF_000000000000000, 4'b0000});
    send(1'b1, 13'd1535, ONE << 120, 6'b100000, {72'h800_000000000000000, 4'b0000});
    drain();

    // Backpressure: third op held by upstream while busy.
    send_model(1'b0, 13'd1600, (ONE << 121) + (ONE << 7), 6'b0);
    send_model(1'b1, 13'd1400, (ONE << 120) + (ONE << 100), 6'b0);
    drive(1'b0, 13'd1700, (ONE << 121) + (ONE << 61), 6'b0);
    stall(3);
    check("busy_passthrough", 76'(oDATA_BUSY), 76'd0);
    send_model(1'b0, 13'd1700, (ONE << 121) + (ONE << 61), 6'b0);
    drain();

    // Sync clear beats a stall with two ops in flight.
    send_model(1'b0, 13'd1535, ONE << 120, 6'b0);
    send_model(1'b1, 13'd1536, ONE << 120, 6'b0);
    iDATA_BUSY  = 1'b1;
    iRESET_SYNC = 1'b1;
    #1;
    check("busy_forwarded", 76'(oDATA_BUSY), 76'd1);
    @(posedge iCLOCK);
    #1;
    sb.delete();
    iRESET_SYNC = 1'b0;
    iDATA_BUSY  = 1'b0;
    check("sync_clear_valid", 76'(oDATA_VALID), 76'd0);
    check("sync_clear_data", {oDATA_DATA, oDATA_FLAGS}, 76'd0);
    repeat (3) @(posedge iCLOCK);
    #1;

    // Asynchronous reset mid-operation.
    send_model(1'b0, 13'd1535, ONE << 120, 6'b0);
    #2;
    iRESET = 1'b1;
    #1;
    check("async_reset_valid", 76'(oDATA_VALID), 76'd0);
    check("async_reset_out", {oDATA_DATA, oDATA_FLAGS}, 76'd0);
    sb.delete();
    @(posedge iCLOCK);
    #1;
    iRESET = 1'b0;
    repeat (3) @(posedge iCLOCK);
    #1;

    // Random products with stalls and bubbles.
    for (int i = 0; i < 300; i++) begin
      a = {1'b1, 28'($urandom), 32'($urandom)};
      b = {1'b1, 28'($urandom), 32'($urandom)};
      case ($urandom_range(0, 7))
        0:       ex = 13'($urandom_range(0, 700));
        1:       ex = 13'($urandom);
        2:       ex = 13'($urandom_range(2400, 2700));
        default: ex = 13'($urandom_range(600, 2600));
      endcase
      xc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b0;
      send_model(1'($urandom), ex, 122'(a) * 122'(b), xc);
      case ($urandom_range(0, 9))
        0:       stall($urandom_range(1, 3));
        1:       begin @(posedge iCLOCK); #1; end
        default: ;
      endcase
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
